// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared constants and fetch-entry type for the fetch stage
// Purpose: default widths, reset PC and PC step used by fetch_unit and its
//          testbench, plus the {pc, data} entry carried through the prefetch queue.
// Ports:   none (package).
package rv_pkg;

  localparam int          PC_W     = 16;
  localparam int          INST_W   = 32;
  localparam int          STEP     = 1;
  localparam int unsigned RESET_PC = 0;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - DEPTH-entry synchronous FIFO with flush and occupancy count
// Purpose: in-order storage used for both the outstanding-request PC FIFO and
//          the instruction prefetch queue.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, push_data write one entry (ignored on flush or when full without pop)
//   pop             remove head entry (ignored when empty or on flush)
//   flush           empty the FIFO; overrides push and pop
//   head_data       current head entry (undefined when count == 0)
//   count           number of stored entries, 0..DEPTH
module fetch_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop  = pop && !flush && (count_q != '0);
    // A full FIFO may still accept a push when the head leaves in the same cycle.
    do_push = push && !flush && ((count_q != FULL) || do_pop);
    // DEPTH is a power of two, so pointers wrap naturally.
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with prefetch queue and redirect flush
// Purpose: owns the PC, issues in-order imem requests, queues {pc, data} for
//          decode, handles redirects by flushing and discarding stale responses.
// Optional feature: FETCH_MISALIGN_TRAP_EN - sticky misalign on redirect_pc % STEP != 0,
//          halting fetch until reset or an aligned redirect; otherwise misalign is 0.
// Ports:
//   sysCLK, nRST                    clock, asynchronous active-low reset
//   redirect_valid, redirect_pc     load new PC and flush
//   imem_req_valid/ready/addr       request channel to instruction memory
//   imem_rsp_valid, imem_rsp_data   in-order response channel
//   inst_valid/ready/data/pc        head of prefetch queue toward decode
//   inst_pc_next                    inst_pc + STEP (link value)
//   misalign                        sticky misaligned-redirect flag
module fetch_unit
  import rv_pkg::*;
#(
  parameter int          PC_W     = rv_pkg::PC_W,
  parameter int          INST_W   = rv_pkg::INST_W,
  parameter int          DEPTH    = 4,
  parameter int          STEP     = rv_pkg::STEP,
  parameter int unsigned RESET_PC = rv_pkg::RESET_PC
) (
  input  logic              sysCLK,
  input  logic              nRST,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [PC_W-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [PC_W-1:0]   inst_pc,
  output logic [PC_W-1:0]   inst_pc_next,
  output logic              misalign
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [PC_W-1:0] STEP_PC   = PC_W'(STEP);
  localparam logic [CW:0]     DEPTH_OCC = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] data;
  } entry_t;

  logic [PC_W-1:0] req_pc_q, req_pc_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]   outstanding, iq_count;
  logic [CW:0]     occ;
  logic [PC_W-1:0] pcq_head;
  entry_t          iq_push, iq_head;
  logic            fire, rsp_take, rsp_drop, pop, halt;

  always_comb begin
    occ            = (CW+1)'(iq_count) + (CW+1)'(outstanding);
    imem_req_valid = nRST && !redirect_valid && !halt && (occ < DEPTH_OCC) && (drop_cnt_q == '0);
    fire           = imem_req_valid && imem_req_ready;
    rsp_drop       = imem_rsp_valid && (drop_cnt_q != '0);
    // Responses with nothing outstanding (e.g. just after reset) are ignored.
    rsp_take       = imem_rsp_valid && (drop_cnt_q == '0) && (outstanding != '0) && !redirect_valid;
    pop            = inst_valid && inst_ready && !redirect_valid;
    iq_push        = '{pc: pcq_head, data: imem_rsp_data};
  end

  always_comb begin
    req_pc_d   = req_pc_q;
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      req_pc_d   = redirect_pc;
      // Everything still owed becomes stale; a response arriving now is one of them.
      drop_cnt_d = drop_cnt_q + outstanding
                 - CW'(imem_rsp_valid && ((drop_cnt_q != '0) || (outstanding != '0)));
    end else begin
      if (fire)     req_pc_d   = req_pc_q + STEP_PC;
      if (rsp_drop) drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge sysCLK or negedge nRST) begin
    if (!nRST) begin
      req_pc_q   <= PC_W'(RESET_PC);
      drop_cnt_q <= '0;
    end else begin
      req_pc_q   <= req_pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;

  always_comb begin
    misalign_d = misalign_q;
    if (redirect_valid) misalign_d = (redirect_pc % STEP_PC) != '0;
  end

  always_ff @(posedge sysCLK or negedge nRST) begin
    if (!nRST) misalign_q <= 1'b0;
    else       misalign_q <= misalign_d;
  end

  assign halt     = misalign_q;
  assign misalign = misalign_q;
`else
  assign halt     = 1'b0;
  assign misalign = 1'b0;
`endif

  // The PC FIFO occupancy is the outstanding-request count.
  fetch_queue #(.WIDTH(PC_W), .DEPTH(DEPTH)) u_pc_fifo (
    .clk       (sysCLK),
    .rst_n     (nRST),
    .push      (fire),
    .push_data (req_pc_q),
    .pop       (rsp_take),
    .flush     (redirect_valid),
    .head_data (pcq_head),
    .count     (outstanding)
  );

  fetch_queue #(.WIDTH(PC_W + INST_W), .DEPTH(DEPTH)) u_inst_queue (
    .clk       (sysCLK),
    .rst_n     (nRST),
    .push      (rsp_take),
    .push_data (iq_push),
    .pop       (pop),
    .flush     (redirect_valid),
    .head_data (iq_head),
    .count     (iq_count)
  );

  assign imem_req_addr = req_pc_q;
  assign inst_valid    = (iq_count != '0);
  assign inst_data     = iq_head.data;
  assign inst_pc       = iq_head.pc;
  assign inst_pc_next  = iq_head.pc + STEP_PC;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        req_valid, req_ready;
  logic [15:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_data;
  logic [15:0] inst_pc, inst_pc_next;
  logic        misalign;

  logic        redirect4;
  logic [15:0] rpc4;
  logic        req_valid4, ready4;
  logic [15:0] req_addr4;
  logic        rsp_valid4;
  logic [31:0] rsp_data4;
  logic        inst_valid4, inst_ready4;
  logic [31:0] inst_data4;
  logic [15:0] inst_pc4, inst_pc_next4;
  logic        misalign4;

  fetch_unit dut (
    .sysCLK(clk), .nRST(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .inst_pc(inst_pc), .inst_pc_next(inst_pc_next), .misalign(misalign)
  );

  fetch_unit #(.PC_W(16), .INST_W(32), .DEPTH(4), .STEP(4), .RESET_PC(16'hFFF8)) dut4 (
    .sysCLK(clk), .nRST(rst_n),
    .redirect_valid(redirect4), .redirect_pc(rpc4),
    .imem_req_valid(req_valid4), .imem_req_ready(ready4), .imem_req_addr(req_addr4),
    .imem_rsp_valid(rsp_valid4), .imem_rsp_data(rsp_data4),
    .inst_valid(inst_valid4), .inst_ready(inst_ready4), .inst_data(inst_data4),
    .inst_pc(inst_pc4), .inst_pc_next(inst_pc_next4), .misalign(misalign4)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Fixed-latency instruction memory for the STEP=1 instance: data = 0xA0000000 | addr.
  typedef struct { logic [15:0] addr; int due; } pend_t;
  pend_t pend[$];
  int    cyc = 0;
  int    lat = 1;

  initial begin
    rsp_valid = 1'b0;
    rsp_data  = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        rsp_valid = 1'b1;
        rsp_data  = 32'hA000_0000 | {16'h0, pend[0].addr};
        void'(pend.pop_front());
      end else begin
        rsp_valid = 1'b0;
      end
      @(negedge clk);
      if (!rst_n) pend.delete();
      else if (req_valid && req_ready) pend.push_back('{req_addr, cyc + lat});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns at the drive point of the first cycle after reset release.
  task automatic do_reset();
    tick(); rst_n = 1'b0;
    tick();
    tick(); rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; req_ready = 1'b0; inst_ready = 1'b0;
    redirect4 = 1'b0; rpc4 = '0; ready4 = 1'b0; rsp_valid4 = 1'b0; rsp_data4 = '0; inst_ready4 = 1'b0;

    // Reset state
    tick(); tick(); #2;
    check("rst_inst_valid", inst_valid, 1'b0);
    check("rst_req_valid", req_valid, 1'b0);
    check("rst_misalign", misalign, 1'b0);
    check("rst_req_addr", req_addr, 16'h0000);
    check("rst_req_addr4", req_addr4, 16'hFFF8);
    check("rst_req_valid4", req_valid4, 1'b0);

    // 1: latency 1, always ready
    lat = 1; req_ready = 1'b1; inst_ready = 1'b1;
    do_reset(); #2;
    check("t1_c0_req_valid", req_valid, 1'b1);
    check("t1_c0_addr", req_addr, 16'h0000);
    tick(); #2;
    check("t1_c1_addr", req_addr, 16'h0001);
    check("t1_c1_inst_valid", inst_valid, 1'b0);
    tick(); #2;
    check("t1_c2_addr", req_addr, 16'h0002);
    check("t1_c2_inst_valid", inst_valid, 1'b1);
    check("t1_c2_inst_pc", inst_pc, 16'h0000);
    check("t1_c2_inst_data", inst_data, 32'hA000_0000);
    check("t1_c2_pc_next", inst_pc_next, 16'h0001);
    tick(); #2;
    check("t1_c3_inst_pc", inst_pc, 16'h0001);
    check("t1_c3_inst_data", inst_data, 32'hA000_0001);
    check("t1_c3_pc_next", inst_pc_next, 16'h0002);
    tick(); #2;
    check("t1_c4_inst_pc", inst_pc, 16'h0002);
    check("t1_c4_addr", req_addr, 16'h0004);

    // 2: decode stalled, exactly DEPTH requests then resume
    lat = 1; inst_ready = 1'b0;
    do_reset(); #2;
    tick(); tick(); tick(); #2;
    check("t2_c3_req_valid", req_valid, 1'b1);
    check("t2_c3_addr", req_addr, 16'h0003);
    tick(); #2;
    check("t2_c4_req_valid", req_valid, 1'b0);
    tick(); #2;
    check("t2_c5_req_valid", req_valid, 1'b0);
    tick(); #2;
    check("t2_c6_req_valid", req_valid, 1'b0);
    check("t2_c6_inst_pc", inst_pc, 16'h0000);
    tick(); inst_ready = 1'b1; #2;
    check("t2_c7_req_valid", req_valid, 1'b0);
    check("t2_c7_inst_pc", inst_pc, 16'h0000);
    tick(); #2;
    check("t2_c8_req_valid", req_valid, 1'b1);
    check("t2_c8_addr", req_addr, 16'h0004);
    check("t2_c8_inst_pc", inst_pc, 16'h0001);
    tick(); #2;
    check("t2_c9_inst_pc", inst_pc, 16'h0002);
    tick(); #2;
    check("t2_c10_inst_pc", inst_pc, 16'h0003);
    tick(); #2;
    check("t2_c11_inst_pc", inst_pc, 16'h0004);
    check("t2_c11_inst_data", inst_data, 32'hA000_0004);

    // 3: latency 3, redirect with two outstanding
    lat = 3; inst_ready = 1'b1;
    do_reset(); #2;
    tick(); #2;
    tick(); redirect_valid = 1'b1; redirect_pc = 16'h0040; #2;
    check("t3_c2_req_valid", req_valid, 1'b0);
    tick(); redirect_valid = 1'b0; #2;
    check("t3_c3_req_valid", req_valid, 1'b0);
    check("t3_c3_inst_valid", inst_valid, 1'b0);
    tick(); #2;
    check("t3_c4_req_valid", req_valid, 1'b0);
    check("t3_c4_inst_valid", inst_valid, 1'b0);
    tick(); #2;
    check("t3_c5_req_valid", req_valid, 1'b1);
    check("t3_c5_addr", req_addr, 16'h0040);
    for (int i = 5; i <= 8; i++) begin
      if (i > 5) begin tick(); #2; end
      check($sformatf("t3_c%0d_no_stale", i), inst_valid, 1'b0);
    end
    tick(); #2;
    check("t3_c9_inst_valid", inst_valid, 1'b1);
    check("t3_c9_inst_pc", inst_pc, 16'h0040);
    check("t3_c9_inst_data", inst_data, 32'hA000_0040);

    // 4: redirect coincident with a response and a pop
    lat = 1; inst_ready = 1'b1;
    do_reset(); #2;
    tick(); #2;
    tick(); redirect_valid = 1'b1; redirect_pc = 16'h0040; #2;
    check("t4_c2_rsp_present", rsp_valid, 1'b1);
    check("t4_c2_inst_valid", inst_valid, 1'b1);
    check("t4_c2_req_valid", req_valid, 1'b0);
    tick(); redirect_valid = 1'b0; #2;
    check("t4_c3_inst_valid", inst_valid, 1'b0);
    check("t4_c3_req_valid", req_valid, 1'b1);
    check("t4_c3_addr", req_addr, 16'h0040);
    tick(); #2;
    check("t4_c4_inst_valid", inst_valid, 1'b0);
    tick(); #2;
    check("t4_c5_inst_valid", inst_valid, 1'b1);
    check("t4_c5_inst_pc", inst_pc, 16'h0040);

    // 5: STEP=4, RESET_PC=0xFFF8, PC wrap
    req_ready = 1'b0; inst_ready = 1'b0;
    ready4 = 1'b1; inst_ready4 = 1'b1; rsp_valid4 = 1'b0;
    do_reset(); #2;
    check("t5_c0_req_valid4", req_valid4, 1'b1);
    check("t5_c0_addr4", req_addr4, 16'hFFF8);
    tick(); rsp_valid4 = 1'b1; rsp_data4 = 32'h0000_1111; #2;
    check("t5_c1_addr4", req_addr4, 16'hFFFC);
    tick(); rsp_data4 = 32'h0000_2222; #2;
    check("t5_c2_addr4", req_addr4, 16'h0000);
    check("t5_c2_inst_valid4", inst_valid4, 1'b1);
    check("t5_c2_inst_pc4", inst_pc4, 16'hFFF8);
    check("t5_c2_pc_next4", inst_pc_next4, 16'hFFFC);
    check("t5_c2_inst_data4", inst_data4, 32'h0000_1111);
    tick(); rsp_valid4 = 1'b0; #2;
    check("t5_c3_inst_pc4", inst_pc4, 16'hFFFC);
    check("t5_c3_pc_next4", inst_pc_next4, 16'h0000);
    check("t5_c3_inst_data4", inst_data4, 32'h0000_2222);

    // 6: misaligned redirect on the STEP=4 instance
    ready4 = 1'b0; rsp_valid4 = 1'b0;
    do_reset(); redirect4 = 1'b1; rpc4 = 16'h0042; #2;
    check("t6_c0_req_valid4", req_valid4, 1'b0);
    tick(); redirect4 = 1'b0; ready4 = 1'b1; #2;
`ifdef FETCH_MISALIGN_TRAP_EN
    check("t6_c1_misalign4", misalign4, 1'b1);
    check("t6_c1_req_valid4", req_valid4, 1'b0);
    tick(); redirect4 = 1'b1; rpc4 = 16'h0044; #2;
    check("t6_c2_misalign4", misalign4, 1'b1);
    check("t6_c2_req_valid4", req_valid4, 1'b0);
    tick(); redirect4 = 1'b0; #2;
    check("t6_c3_misalign4", misalign4, 1'b0);
    check("t6_c3_req_valid4", req_valid4, 1'b1);
    check("t6_c3_addr4", req_addr4, 16'h0044);
`else
    check("t6_c1_misalign4", misalign4, 1'b0);
    check("t6_c1_req_valid4", req_valid4, 1'b1);
    check("t6_c1_addr4", req_addr4, 16'h0042);
`endif
    check("t6_misalign_step1", misalign, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
